// File: rtl/series_ctrl_pkg.sv
// Shared types and constants for the series-evaluation controller:
// FSM state encoding, datapath control word and its per-state decode.
package series_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MUL_A,
        S_MUL_B,
        S_ACC,
        S_STEP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic sel_x;
        logic sel_t;
        logic sel_1;
        logic sel_2;
        logic load_x;
        logic load_m;
        logic load_t;
        logic counter_en;
        logic cntr_clr;
    } ctrl_t;

    localparam logic [15:0] ONE_Q88  = 16'h0100;
    localparam logic        MODE_ADD = 1'b0;
    localparam logic        MODE_SUB = 1'b1;

    // Moore part of the control word; mode is handled separately because it
    // depends on lsb_counter.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_INIT: begin
                c.load_x   = 1'b1;
                c.load_t   = 1'b1;
                c.cntr_clr = 1'b1;
            end
            S_MUL_A: begin
                c.sel_2  = 1'b1;
                c.sel_t  = 1'b1;
                c.load_t = 1'b1;
            end
            S_MUL_B: begin
                c.sel_x  = 1'b1;
                c.load_x = 1'b1;
            end
            S_ACC:   c.load_m     = 1'b1;
            S_STEP:  c.counter_en = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/series_controller.sv
// Sequencer for the Q8.8 series-evaluation datapath: one MUL_A/MUL_B/ACC/STEP
// pass per term, terminating on the last term or on the comparator's gt flag.
module series_controller
    import series_ctrl_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic gt,
    input  logic lsb_counter,
    output logic ready,
    output logic done,
    output logic early_stop,
    output logic cntr_clr,
    output logic counter_en,
    output logic sel_x,
    output logic sel_t,
    output logic sel_1,
    output logic sel_2,
    output logic load_x,
    output logic load_m,
    output logic load_t,
    output logic mode
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_TERMS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_iter;
    logic             r_early_stop;
    ctrl_t            w_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_INIT;
            S_INIT:  w_next = S_MUL_A;
            S_MUL_A: w_next = S_MUL_B;
            S_MUL_B: w_next = S_ACC;
            S_ACC:   w_next = S_STEP;
            S_STEP: begin
                if (gt || (r_iter == LAST_ITER)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_MUL_A;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Iteration count saturates so it can never step past the last term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter       <= '0;
            r_early_stop <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_iter <= '0;
            end else if ((r_state == S_STEP) && (r_iter != LAST_ITER)) begin
                r_iter <= r_iter + CNT_W'(1);
            end

            if ((r_state == S_IDLE) && start) begin
                r_early_stop <= 1'b0;
            end else if ((r_state == S_STEP) && gt) begin
                r_early_stop <= 1'b1;
            end
        end
    end

    assign w_ctrl     = decode_ctrl(r_state);
    assign sel_x      = w_ctrl.sel_x;
    assign sel_t      = w_ctrl.sel_t;
    assign sel_1      = w_ctrl.sel_1;
    assign sel_2      = w_ctrl.sel_2;
    assign load_x     = w_ctrl.load_x;
    assign load_m     = w_ctrl.load_m;
    assign load_t     = w_ctrl.load_t;
    assign counter_en = w_ctrl.counter_en;
    assign cntr_clr   = w_ctrl.cntr_clr;

    // Odd terms of the series subtract.
    assign mode       = ((r_state == S_ACC) && lsb_counter) ? MODE_SUB : MODE_ADD;
    assign ready      = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);
    assign early_stop = r_early_stop;

endmodule

// File: tb/tb_series_controller.sv
// Directed testbench for series_controller: N_TERMS=8 main instance plus an
// N_TERMS=1 instance for the single-term boundary.
module tb_series_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, gt, lsb_counter;
    logic ready, done, early_stop, cntr_clr, counter_en;
    logic sel_x, sel_t, sel_1, sel_2, load_x, load_m, load_t, mode;

    logic u1_start, u1_gt, u1_lsb_counter;
    logic u1_ready, u1_done, u1_early_stop, u1_cntr_clr, u1_counter_en;
    logic u1_sel_x, u1_sel_t, u1_sel_1, u1_sel_2, u1_load_x, u1_load_m, u1_load_t, u1_mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] obs [0:63];
    int done_cyc;
    int pulses;

    series_controller #(.N_TERMS(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .gt(gt), .lsb_counter(lsb_counter),
        .ready(ready), .done(done), .early_stop(early_stop), .cntr_clr(cntr_clr),
        .counter_en(counter_en), .sel_x(sel_x), .sel_t(sel_t), .sel_1(sel_1),
        .sel_2(sel_2), .load_x(load_x), .load_m(load_m), .load_t(load_t), .mode(mode)
    );

    series_controller #(.N_TERMS(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(u1_start), .gt(u1_gt), .lsb_counter(u1_lsb_counter),
        .ready(u1_ready), .done(u1_done), .early_stop(u1_early_stop), .cntr_clr(u1_cntr_clr),
        .counter_en(u1_counter_en), .sel_x(u1_sel_x), .sel_t(u1_sel_t), .sel_1(u1_sel_1),
        .sel_2(u1_sel_2), .load_x(u1_load_x), .load_m(u1_load_m), .load_t(u1_load_t),
        .mode(u1_mode)
    );

    // {ready, done, cntr_clr, counter_en, sel_x, sel_t, sel_1, sel_2, load_x, load_m, load_t, mode}
    function automatic logic [11:0] pack_obs();
        return {ready, done, cntr_clr, counter_en, sel_x, sel_t,
                sel_1, sel_2, load_x, load_m, load_t, mode};
    endfunction

    function automatic logic [11:0] pack_obs_u1();
        return {u1_ready, u1_done, u1_cntr_clr, u1_counter_en, u1_sel_x, u1_sel_t,
                u1_sel_1, u1_sel_2, u1_load_x, u1_load_m, u1_load_t, u1_mode};
    endfunction

    // Expected control pattern for cycle c of a run whose DONE falls in cycle last;
    // ACC mode follows the 0,1,0,1 lsb_counter stimulus driven by do_run.
    function automatic logic [11:0] exp_obs(input int c, input int last);
        if (c == 1)   return 12'h20A;
        if (c > last) return 12'h800;
        if (c == last) return 12'h400;
        case ((c - 2) % 4)
            0:       return 12'h052;
            1:       return 12'h088;
            2:       return 12'h004 | 12'(((c - 4) / 4) % 2);
            default: return 12'h100;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one run from IDLE on the N_TERMS=8 instance and records outputs per
    // cycle until two cycles after done (or a 63-cycle bound).
    task automatic do_run(input int gt_from, input int gt_to, input logic lsb_other,
                          input bit hold_start, input bit poke_start);
        bit is_acc;
        start    = 1'b1;
        tick();
        start    = hold_start;
        done_cyc = -1;
        pulses   = 0;
        for (int c = 1; c < 64; c++) begin
            if (c > 1) tick();
            is_acc = (c >= 4) && (((c - 4) % 4) == 0);
            gt     = (c >= gt_from) && (c <= gt_to);
            lsb_counter = is_acc ? logic'(((c - 4) / 4) % 2) : lsb_other;
            if (poke_start) start = (c == 2) || (c == 34);
            #1;
            obs[c] = pack_obs();
            if (counter_en) pulses++;
            if (done && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 2) break;
        end
        gt = 1'b0;
        start = 1'b0;
        lsb_counter = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; gt = 1'b0; lsb_counter = 1'b0;
        u1_start = 1'b0; u1_gt = 1'b0; u1_lsb_counter = 1'b0;
        #12;
        n_checks++;
        if (pack_obs() !== 12'h800) begin
            n_fail++;
            $display("FAIL reset_outputs: got %03h expected %03h", pack_obs(), 12'h800);
        end
        n_checks++;
        if (early_stop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_early_stop: got %b expected 0", early_stop);
        end
        n_checks++;
        if (pack_obs_u1() !== 12'h800) begin
            n_fail++;
            $display("FAIL reset_u1_outputs: got %03h expected %03h", pack_obs_u1(), 12'h800);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (pack_obs() !== 12'h800) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %03h expected %03h", pack_obs(), 12'h800);
        end
    endtask

    task automatic test_full_run();
        do_run(100, 0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (done_cyc !== 34) begin
            n_fail++;
            $display("FAIL full_done_cycle: got %0d expected 34", done_cyc);
        end
        n_checks++;
        if (pulses !== 8) begin
            n_fail++;
            $display("FAIL full_counter_en_pulses: got %0d expected 8", pulses);
        end
        n_checks++;
        if (early_stop !== 1'b0) begin
            n_fail++;
            $display("FAIL full_early_stop: got %b expected 0", early_stop);
        end
        for (int c = 1; c <= 36; c++) begin
            n_checks++;
            if (obs[c] !== exp_obs(c, 34)) begin
                n_fail++;
                $display("FAIL full_cycle_%0d: got %03h expected %03h", c, obs[c], exp_obs(c, 34));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int bad_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (pack_obs() !== 12'h088) begin
            n_fail++;
            $display("FAIL midrun_in_mul_b: got %03h expected %03h", pack_obs(), 12'h088);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (pack_obs() !== 12'h800) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got %03h expected %03h", pack_obs(), 12'h800);
        end
        tick();
        rst = 1'b0;
        bad_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || !ready) bad_done++;
        end
        n_checks++;
        if (bad_done !== 0) begin
            n_fail++;
            $display("FAIL midrun_idle_after_reset: got %0d non-idle cycles expected 0", bad_done);
        end
        do_run(100, 0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (done_cyc !== 34 || pulses !== 8) begin
            n_fail++;
            $display("FAIL midrun_rerun: got done %0d pulses %0d expected done 34 pulses 8",
                     done_cyc, pulses);
        end
    endtask

    task automatic test_early_stop();
        bit seen;
        do_run(10, 13, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (done_cyc !== 14) begin
            n_fail++;
            $display("FAIL early_done_cycle: got %0d expected 14", done_cyc);
        end
        n_checks++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL early_counter_en_pulses: got %0d expected 3", pulses);
        end
        for (int c = 1; c <= 16; c++) begin
            n_checks++;
            if (obs[c] !== exp_obs(c, 14)) begin
                n_fail++;
                $display("FAIL early_cycle_%0d: got %03h expected %03h", c, obs[c], exp_obs(c, 14));
            end
        end
        tick(); tick(); tick();
        n_checks++;
        if (early_stop !== 1'b1) begin
            n_fail++;
            $display("FAIL early_stop_held: got %b expected 1", early_stop);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (early_stop !== 1'b0 || cntr_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL early_stop_cleared: got early_stop %b cntr_clr %b expected 0 1",
                     early_stop, cntr_clr);
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        tick();
        n_checks++;
        if (!seen || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_next_run_completes: got done_seen %b ready %b expected 1 1",
                     seen, ready);
        end
    endtask

    task automatic test_mode();
        do_run(100, 0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (done_cyc !== 34) begin
            n_fail++;
            $display("FAIL mode_done_cycle: got %0d expected 34", done_cyc);
        end
        for (int c = 1; c <= 34; c++) begin
            n_checks++;
            if (obs[c] !== exp_obs(c, 34)) begin
                n_fail++;
                $display("FAIL mode_cycle_%0d: got %03h expected %03h", c, obs[c], exp_obs(c, 34));
            end
        end
    endtask

    task automatic test_start_ignored();
        do_run(100, 0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs[2] !== 12'h052 || obs[3] !== 12'h088) begin
            n_fail++;
            $display("FAIL ignore_start_mul_a: got %03h %03h expected 052 088", obs[2], obs[3]);
        end
        n_checks++;
        if (done_cyc !== 34) begin
            n_fail++;
            $display("FAIL ignore_done_cycle: got %0d expected 34", done_cyc);
        end
        n_checks++;
        if (obs[35] !== 12'h800 || obs[36] !== 12'h800) begin
            n_fail++;
            $display("FAIL ignore_start_done: got %03h %03h expected 800 800", obs[35], obs[36]);
        end
    endtask

    task automatic test_start_held();
        do_run(100, 0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (done_cyc !== 34) begin
            n_fail++;
            $display("FAIL held_done_cycle: got %0d expected 34", done_cyc);
        end
        n_checks++;
        if (obs[35] !== 12'h800) begin
            n_fail++;
            $display("FAIL held_idle_cycle: got %03h expected %03h", obs[35], 12'h800);
        end
        n_checks++;
        if (obs[36] !== 12'h20A) begin
            n_fail++;
            $display("FAIL held_restart_init: got %03h expected %03h", obs[36], 12'h20A);
        end
        rst = 1'b1;
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic u1_run(input bit gt_last, output int dc, output int pl);
        u1_start = 1'b1;
        tick();
        u1_start = 1'b0;
        dc = -1;
        pl = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) tick();
            u1_gt = gt_last && (c == 5);
            #1;
            if (u1_counter_en) pl++;
            if (u1_done) begin
                dc = c;
                break;
            end
        end
        u1_gt = 1'b0;
        tick();
    endtask

    task automatic test_single_term();
        int dc, pl;
        u1_run(1'b0, dc, pl);
        n_checks++;
        if (dc !== 6 || pl !== 1 || u1_early_stop !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_gt: got done %0d pulses %0d es %b expected 6 1 0",
                     dc, pl, u1_early_stop);
        end
        u1_run(1'b1, dc, pl);
        n_checks++;
        if (dc !== 6 || pl !== 1 || u1_early_stop !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gt_last: got done %0d pulses %0d es %b expected 6 1 1",
                     dc, pl, u1_early_stop);
        end
        n_checks++;
        if (u1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_back_to_idle: got %b expected 1", u1_ready);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_reset_midrun();
        test_early_stop();
        test_mode();
        test_start_ignored();
        test_start_held();
        test_single_term();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
